// File: rtl/player_motion_ctrl.sv
// Per-frame player kinematics: button conditioning, run, jump and gravity.
// State advances only on frame_tick so the renderer sees stable coordinates.
module player_motion_ctrl #(
   parameter int PLAYER_SIZE_X = 37,
   parameter int PLAYER_SIZE_Y = 42,
   parameter int SCREEN_W      = 640,
   parameter int GROUND_Y      = 400,
   parameter int START_X       = 40,
   parameter int RUN_SPEED     = 3,
   parameter int JUMP_VEL      = 12,
   parameter int GRAVITY       = 1,
   parameter int MAX_FALL      = 8
) (
   input  logic        VGA_clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [3:0]  game_state,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   output logic [15:0] playerX,
   output logic [15:0] playerY,
   output logic        player_dir,
   output logic [3:0]  player_state
);
   localparam int X_MAX = SCREEN_W - PLAYER_SIZE_X;
   localparam logic [15:0]        LP_START_X = 16'(START_X);
   localparam logic [15:0]        LP_GROUND  = 16'(GROUND_Y);
   localparam logic [15:0]        LP_RUN     = 16'(RUN_SPEED);
   localparam logic [15:0]        LP_JUMP    = 16'(JUMP_VEL);
   localparam logic [15:0]        LP_XMAX    = 16'(X_MAX);
   localparam logic signed [7:0]  LP_VJUMP   = 8'(-JUMP_VEL);
   localparam logic signed [8:0]  LP_GRAV9   = 9'(GRAVITY);
   localparam logic signed [8:0]  LP_MAXF9   = 9'(MAX_FALL);
   localparam logic signed [16:0] LP_GND17   = 17'(GROUND_Y);

   if (PLAYER_SIZE_Y <= 0 || X_MAX <= 0 || JUMP_VEL > 127 || MAX_FALL > 127) begin : g_bad_param
      $error("player_motion_ctrl: illegal parameter set");
   end

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_RUN  = 4'd1,
      S_JUMP = 4'd2,
      S_FALL = 4'd3
   } state_t;

   logic [2:0]        r_sync1, r_sync2;
   logic              r_jmp_d, r_jump_req;
   logic [15:0]       r_x, r_y;
   logic signed [7:0] r_vy;
   logic              r_dir;
   state_t            r_state;

   logic              w_left, w_right, w_jump;
   logic [16:0]       w_x_inc;
   logic signed [8:0] w_vy_sum, w_vy_fall;
   logic signed [16:0] w_y_sum;
   logic [15:0]       w_x_n, w_y_n;
   logic signed [7:0] w_vy_n;
   logic              w_dir_n;
   state_t            w_state_n, w_gnd_state;

   assign w_left  = r_sync2[0];
   assign w_right = r_sync2[1];
   // An edge arriving on the tick cycle itself still counts for that tick.
   assign w_jump  = r_jump_req | (r_sync2[2] & ~r_jmp_d);

   // State register
   always_ff @(posedge VGA_clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_jmp_d    <= 1'b0;
         r_jump_req <= 1'b0;
         r_x        <= LP_START_X;
         r_y        <= LP_GROUND;
         r_vy       <= '0;
         r_dir      <= 1'b1;
         r_state    <= S_IDLE;
      end else begin
         r_sync1    <= {btn_jump, btn_right, btn_left};
         r_sync2    <= r_sync1;
         r_jmp_d    <= r_sync2[2];
         r_jump_req <= frame_tick ? 1'b0 : w_jump;
         r_x        <= w_x_n;
         r_y        <= w_y_n;
         r_vy       <= w_vy_n;
         r_dir      <= w_dir_n;
         r_state    <= w_state_n;
      end
   end

   // Next-state logic
   always_comb begin
      w_x_n       = r_x;
      w_y_n       = r_y;
      w_vy_n      = r_vy;
      w_dir_n     = r_dir;
      w_state_n   = r_state;
      w_x_inc     = {1'b0, r_x} + {1'b0, LP_RUN};
      w_vy_sum    = $signed({r_vy[7], r_vy}) + LP_GRAV9;
      w_vy_fall   = (w_vy_sum > LP_MAXF9) ? LP_MAXF9 : w_vy_sum;
      w_y_sum     = $signed({1'b0, r_y}) + $signed({{8{w_vy_fall[8]}}, w_vy_fall});
      w_gnd_state = (w_left ^ w_right) ? S_RUN : S_IDLE;
      if (frame_tick) begin
         if (game_state == 4'd1) begin
            if (w_left && !w_right) begin
               w_x_n   = (r_x < LP_RUN) ? 16'd0 : r_x - LP_RUN;
               w_dir_n = 1'b0;
            end else if (w_right && !w_left) begin
               w_x_n   = (w_x_inc > {1'b0, LP_XMAX}) ? LP_XMAX : w_x_inc[15:0];
               w_dir_n = 1'b1;
            end
            if (r_state == S_JUMP || r_state == S_FALL) begin
               if (w_y_sum >= LP_GND17) begin
                  w_y_n     = LP_GROUND;
                  w_vy_n    = '0;
                  w_state_n = w_gnd_state;
               end else if (w_y_sum[16]) begin
                  w_y_n     = '0;
                  w_vy_n    = '0;
                  w_state_n = S_FALL;
               end else begin
                  w_y_n     = w_y_sum[15:0];
                  w_vy_n    = w_vy_fall[7:0];
                  w_state_n = w_vy_fall[8] ? S_JUMP : S_FALL;
               end
            end else if (w_jump) begin
               w_y_n     = r_y - LP_JUMP;
               w_vy_n    = LP_VJUMP;
               w_state_n = S_JUMP;
            end else begin
               w_y_n     = LP_GROUND;
               w_vy_n    = '0;
               w_state_n = w_gnd_state;
            end
         end else if (game_state == 4'd0) begin
            w_x_n     = LP_START_X;
            w_y_n     = LP_GROUND;
            w_vy_n    = '0;
            w_dir_n   = 1'b1;
            w_state_n = S_IDLE;
         end
      end
   end

   // Outputs
   always_comb begin
      playerX      = r_x;
      playerY      = r_y;
      player_dir   = r_dir;
      player_state = r_state;
   end
endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Upstream stage of the frame renderer. Produces `playerX`, `playerY`, `player_dir` and `player_state` for the renderer, which draws the player sprite at those coordinates.
- Integrates button input, horizontal run motion, jump and gravity once per video frame.
- Updates only on a one-cycle `frame_tick` issued by the VGA timing block during vertical blanking, so the renderer sees stable coordinates for a whole visible frame.

Parameters:
- PLAYER_SIZE_X, 37, sprite width in pixels.
- PLAYER_SIZE_Y, 42, sprite height in pixels (reserved for ceiling checks, unused for flat ground).
- SCREEN_W, 640, visible width; X_MAX = SCREEN_W - PLAYER_SIZE_X = 603.
- GROUND_Y, 400, `playerY` value when standing on the ground.
- START_X, 40, spawn X.
- RUN_SPEED, 3, pixels per frame of horizontal motion.
- JUMP_VEL, 12, initial upward speed in pixels per frame.
- GRAVITY, 1, speed increment per frame.
- MAX_FALL, 8, terminal downward speed.

Ports:
- VGA_clk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, synchronous to VGA_clk.
- game_state  in  4  0 start, 1 play, 2 pause, 3 win, 4 lose.
- btn_left  in  1  raw, asynchronous button.
- btn_right  in  1  raw, asynchronous button.
- btn_jump  in  1  raw, asynchronous button.
- playerX  out  16  sprite left edge.
- playerY  out  16  sprite top edge.
- player_dir  out  1  1 = facing right (unmirrored sprite), 0 = left.
- player_state  out  4  0 IDLE, 1 RUN, 2 JUMP, 3 FALL; other codes unused.

Behaviour:
- Reset (asynchronous): `playerX` = START_X, `playerY` = GROUND_Y, `player_dir` = 1, `player_state` = IDLE.
  - Also cleared: internal vy = 0, jump request = 0, synchronizer flops = 0.
  - A reset mid-jump returns the player to ground immediately.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer.
  - A synchronized rising edge of `btn_jump` sets a sticky `jump_req`.
  - `jump_req` clears on every `frame_tick`, consumed or not.
  - A rising edge in the same cycle as `frame_tick` is counted for that tick.
- Update gating: all state updates happen only on `frame_tick`. Outputs change on the cycle after the tick, a one-cycle registered latency.
  - game_state = 1: full update, as below.
  - game_state = 0: on a tick, reload the reset values except the synchronizers.
  - Any other game_state value (pause, win, lose, undefined): hold everything.
- Horizontal motion, per tick in play:
  - Left only: X = (X < RUN_SPEED) ? 0 : X - RUN_SPEED; dir = 0.
  - Right only: X = min(X + RUN_SPEED, X_MAX); dir = 1.
  - Both or neither: X and dir unchanged.
  - Horizontal motion applies in every state, including in the air.
- Vertical state machine, per tick in play:
  - IDLE/RUN with `jump_req` set: vy = -JUMP_VEL, Y = Y - JUMP_VEL, state = JUMP.
  - IDLE/RUN without a jump: Y stays GROUND_Y and vy = 0. State = RUN if exactly one of left/right is held, else IDLE.
  - JUMP/FALL: vy_n = min(vy + GRAVITY, MAX_FALL) and Y_n = Y + vy_n, computed in 17-bit signed arithmetic.
    - If Y_n >= GROUND_Y: Y = GROUND_Y, vy = 0, state = RUN or IDLE by the rule above.
    - Else if Y_n < 0: Y = 0, vy = 0, state = FALL.
    - Else: Y = Y_n, state = JUMP when vy_n < 0, FALL when vy_n >= 0.
  - `jump_req` is ignored while in JUMP or FALL; there is no double jump.
- vy is an 8-bit signed register. Parameters are constrained so that JUMP_VEL <= 127 and MAX_FALL <= 127.

Test Plan:
- Reset, then release `rst` → X = 40, Y = 400, dir = 1, state = 0. `frame_tick` with no buttons → all outputs unchanged.
- game_state = 1, `btn_right` held for 10 ticks → X = 70, dir = 1, state = 1. Continue until X = 603, then one more tick → X stays 603. Hold both buttons → state = 0 and X unchanged.
- From X = 2, `btn_left` held → after one tick X = 0, dir = 0. Next tick → X = 0.
- Jump pulse, then ticks:
  - tick 1 → Y = 388, state = 2.
  - tick 12 → Y = 322, state = 2.
  - tick 13 → Y = 322, state = 3.
  - tick 21 → Y = 358.
  - tick 26 → Y = 398.
  - tick 27 → Y = 400, state = 0.
  - A second jump pulse at tick 5 is ignored.
- Mid-jump, set game_state = 2 for 20 ticks → Y and state frozen. Return to 1 → the trajectory resumes unchanged. Set game_state = 0 and tick → X = 40, Y = 400, state = 0.
- Assert `rst` asynchronously mid-jump (no clock edge) → outputs at reset values immediately. Jump edge coincident with `frame_tick` → jump taken on that tick.
